alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; power of two, 8..64.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  in  1  abort any in-flight operation.
REQ-005 SHALL have port in_valid  in  1  operands and op presented.
REQ-006 SHALL have port in_ready  out  1  unit can accept; high only in IDLE.
REQ-007 SHALL have ports A, B  in  WIDTH  operands.
REQ-008 SHALL have port alu_op  in  5  operation; op[4]=0 base, op[4]=1 multiply/divide.
REQ-009 SHALL have port out_valid  out  1  result held valid.
REQ-010 SHALL have port out_ready  in  1  consumer accepts result.
REQ-011 SHALL have ports alu_out  out  WIDTH  result, and out_zero  out  1  alu_out==0.

Function
REQ-012 Base ops SHALL be (op[3:0]): 0000 ADD, 0001 SUB, 0010 SLL, 0100 SLT, 0110 SLTU, 1000 XOR, 1010 SRL, 1011 SRA, 1100 OR, 1110 AND; other codes yield 0.
REQ-013 Shifts SHALL use only B[log2(WIDTH)-1:0] as the amount.
REQ-014 M ops SHALL be (op[2:0]): 000 MUL low, 001 MULH ss, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; op[3] ignored.
REQ-015 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-016 Acceptance SHALL occur on a clk edge with in_valid & in_ready; A, B, alu_op captured then.
REQ-017 Base op: IDLE->DONE at the accepting edge; out_valid high the cycle after acceptance (latency 1).
REQ-018 M op: IDLE->CALC; CALC lasts exactly WIDTH cycles (one shift-add or restoring-subtract step per cycle, iteration counter); CALC->FIX; FIX applies sign correction; FIX->DONE; out_valid high WIDTH+2 cycles after acceptance.
REQ-019 Signed M ops SHALL operate on magnitudes and negate the result in FIX as required; remainder sign follows dividend.
REQ-020 Divide by zero: DIV/DIVU SHALL give all ones; REM/REMU SHALL give A.
REQ-021 Signed overflow (A=most negative, B=-1): DIV SHALL give A; REM SHALL give 0.
REQ-022 DONE SHALL hold alu_out, out_zero, out_valid stable until out_ready; DONE->IDLE on the edge with out_ready high.
REQ-023 in_ready SHALL be low in CALC, FIX, DONE; no new acceptance before the result is consumed.
REQ-024 flush high SHALL force IDLE at the next edge from any state, drop out_valid, discard the result; flush overrides in_valid and out_ready in that cycle.
REQ-025 alu_out SHALL be registered; no combinational path from A/B to alu_out.

Reset
REQ-026 rst high at an edge SHALL set state IDLE, out_valid 0, alu_out 0, out_zero 1, iteration counter 0; overrides flush and handshakes.
REQ-027 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-028 rst mid-operation SHALL abandon the operation with no out_valid pulse.

Configuration
REQ-029 Macro MULDIV_EN defined: M ops behave per REQ-014..REQ-021.
REQ-030 MULDIV_EN undefined: CALC/FIX logic and iterative datapath SHALL be absent; op[4]=1 completes as a base op with latency 1 and alu_out 0.

Verification (WIDTH=32, MULDIV_EN defined unless stated)
REQ-031 ADD A=0x7FFFFFFF B=1 -> alu_out 0x80000000, out_valid 1 cycle after accept, held 3 cycles with out_ready low, IDLE after out_ready.
REQ-032 MULH A=B=0x80000000 -> 0x40000000, out_valid exactly 34 cycles after accept; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIV -7/2 -> -3, REM -> -1.
REQ-034 SRA A=0x80000000 B=0x21 -> 0xC0000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-035 flush 10 cycles into DIV -> no out_valid, in_ready 1 next cycle, following ADD 2+3 -> 5; repeat with rst instead of flush -> same.
REQ-036 MULDIV_EN undefined: MUL 3*4 -> alu_out 0, out_zero 1, latency 1.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-issue ALU with an optional iterative multiply/divide unit.
// Base ops complete one cycle after acceptance. With MULDIV_EN defined, M ops
// run WIDTH shift-add / restoring-subtract steps in CALC, then FIX applies the
// sign correction. Without MULDIV_EN, M ops complete like base ops and return 0.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             out_zero
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;

  // Single-cycle base operation; shift amount uses only the low log2(WIDTH) bits of b.
  function automatic logic [WIDTH-1:0] base_alu(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SW-1:0]           sh;
    logic [WIDTH-1:0]        r;
    a_s = a;
    b_s = b;
    sh  = b[SW-1:0];
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a << sh;
      4'b0100: r = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'b0110: r = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1000: r = a ^ b;
      4'b1010: r = a >> sh;
      4'b1011: r = a_s >>> sh;
      4'b1100: r = a | b;
      4'b1110: r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] base_res;

  // Base result from the presented operands; it is registered on the accepting edge.
  always_comb begin
`ifdef MULDIV_EN
    base_res = base_alu(alu_op[3:0], A, B);
`else
    base_res = alu_op[4] ? '0 : base_alu(alu_op[3:0], A, B);
`endif
  end

  assign in_ready = (state == IDLE) && !rst;

`ifdef MULDIV_EN
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  logic [SW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;   // mul: {hi, multiplier/lo}; div: {remainder, quotient}
  logic [WIDTH-1:0]   mc;     // multiplicand or divisor magnitude
  logic [2:0]         mop;
  logic               neg;    // negate the selected result in FIX
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;

  // One shift-add multiply step: add multiplicand when the current LSB is set, then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] hi;
    hi = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {hi, p[WIDTH-1:1]};
  endfunction

  // One restoring-divide step: shift in the next dividend bit and subtract if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] t;
    t = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, d};
    if (!t[WIDTH]) return {t[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    else           return {p[2*WIDTH-2:0], 1'b0};
  endfunction

  // Sign correction and result selection once the magnitude computation is finished.
  function automatic logic [WIDTH-1:0] fix_result(input logic [2:0]         op,
                                                  input logic [2*WIDTH-1:0] p,
                                                  input logic               n);
    logic [2*WIDTH-1:0] pn;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r;
    pn = n ? -p : p;
    q  = p[WIDTH-1:0];
    r  = p[2*WIDTH-1:WIDTH];
    if (!op[2])      return (op[1:0] == 2'b00) ? p[WIDTH-1:0] : pn[2*WIDTH-1:WIDTH];
    else if (!op[1]) return n ? -q : q;
    else             return n ? -r : r;
  endfunction

  // Operand signedness and magnitudes for the M op being presented.
  always_comb begin
    sa = A[WIDTH-1] && (alu_op[2:0] == 3'b001 || alu_op[2:0] == 3'b010 ||
                        alu_op[2:0] == 3'b100 || alu_op[2:0] == 3'b110);
    sb = B[WIDTH-1] && (alu_op[2:0] == 3'b001 || alu_op[2:0] == 3'b100 ||
                        alu_op[2:0] == 3'b110);
    ma = sa ? -A : A;
    mb = sb ? -B : B;
  end

  // Iterative datapath: load magnitudes on acceptance, one step per CALC cycle.
  // Remainder sign follows the dividend; a zero divisor never negates the quotient,
  // so DIV by zero yields all ones and REM by zero yields A.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid && alu_op[4]) begin
      mop  <= alu_op[2:0];
      mc   <= alu_op[2] ? mb : ma;
      prod <= {{WIDTH{1'b0}}, (alu_op[2] ? ma : mb)};
      neg  <= (alu_op[2] && alu_op[1]) ? sa
                                       : ((sa ^ sb) && !(alu_op[2] && (B == '0)));
    end else if (state == CALC) begin
      prod <= mop[2] ? div_step(prod, mc) : mul_step(prod, mc);
    end
  end
`endif

  // Control FSM with registered result, zero flag and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      out_zero  <= 1'b1;
`ifdef MULDIV_EN
      cnt       <= '0;
`endif
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
`ifdef MULDIV_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef MULDIV_EN
            if (alu_op[4]) begin
              state <= CALC;
              cnt   <= '0;
            end else
`endif
            begin
              alu_out   <= base_res;
              out_zero  <= (base_res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
`ifdef MULDIV_EN
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          alu_out   <= fix_result(mop, prod, neg);
          out_zero  <= (fix_result(mop, prod, neg) == '0);
          out_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (WIDTH=32) with an expected-result scoreboard.
// Works with or without MULDIV_EN defined.
module tb_alu_muldiv;
  localparam int W = 32;
`ifdef MULDIV_EN
  localparam int MLAT = W + 2;
`else
  localparam int MLAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [W-1:0] A, B, alu_out;
  logic [4:0]   alu_op;

  int nvec  = 0;
  int nfail = 0;
  int seen;
  logic [W-1:0] want_q[$];
  int           lat_q[$];

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    nvec++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for its result, check latency/value/hold, then consume it.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] want, input int lat,
                        input int hold);
    int n;
    logic [W-1:0] e;
    int el;
    want_q.push_back(want);
    lat_q.push_back(lat);
    chk({tag, ".rdy"}, in_ready, 1);
    alu_op = op; A = a; B = b; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; A = $urandom; B = $urandom;
    n = 1;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
    e  = want_q.pop_front();
    el = lat_q.pop_front();
    chk({tag, ".lat"}, n, el);
    chk({tag, ".val"}, alu_out, e);
    chk({tag, ".zero"}, out_zero, (e == '0));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, ".hold"}, {out_valid, in_ready, alu_out}, {1'b1, 1'b0, e});
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, ".idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; alu_op = '0;
    tick;
    tick;
    chk("reset", {in_ready, out_valid, out_zero, alu_out}, {1'b0, 1'b0, 1'b1, 32'h0});
    rst = 1'b0;
    tick;
    chk("reset.release", in_ready, 1);

    // base operations
    run_op("add",   5'b00000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 3);
    run_op("sub",   5'b00001, 32'h5,        32'h7,        32'hFFFFFFFE, 1, 0);
    run_op("sll",   5'b00010, 32'h1,        32'h3F,       32'h80000000, 1, 0);
    run_op("slt",   5'b00100, 32'hFFFFFFFF, 32'h1,        32'h1,        1, 0);
    run_op("sltu",  5'b00110, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0);
    run_op("xor",   5'b01000, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFF005A5A, 1, 0);
    run_op("srl",   5'b01010, 32'h80000000, 32'h21,       32'h40000000, 1, 0);
    run_op("sra",   5'b01011, 32'h80000000, 32'h21,       32'hC0000000, 1, 0);
    run_op("or",    5'b01100, 32'h12340000, 32'h00005678, 32'h12345678, 1, 0);
    run_op("and",   5'b01110, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1, 0);
    run_op("undef", 5'b00011, 32'h12345678, 32'h1,        32'h0,        1, 0);

`ifdef MULDIV_EN
    run_op("mul",    5'b11000, 32'h3,        32'h4,        32'hC,        MLAT, 0);
    run_op("mulh",   5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, MLAT, 2);
    run_op("mulhu",  5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MLAT, 0);
    run_op("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, MLAT, 0);
    run_op("divu0",  5'b10101, 32'h1234,     32'h0,        32'hFFFFFFFF, MLAT, 0);
    run_op("rem0",   5'b10110, 32'h1234,     32'h0,        32'h1234,     MLAT, 0);
    run_op("div0n",  5'b10100, 32'hFFFFFFF8, 32'h0,        32'hFFFFFFFF, MLAT, 0);
    run_op("divovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MLAT, 0);
    run_op("removf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        MLAT, 0);
    run_op("div-7",  5'b10100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, MLAT, 0);
    run_op("rem-7",  5'b10110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, MLAT, 0);
    run_op("div7n",  5'b11100, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, MLAT, 0);
    run_op("divu",   5'b10101, 32'd100,      32'd7,        32'd14,       MLAT, 0);
    run_op("remu",   5'b10111, 32'd100,      32'd7,        32'd2,        MLAT, 0);

    // flush ten cycles into a divide
    alu_op = 5'b10100; A = 32'd100; B = 32'd3; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush.calc", {out_valid, in_ready}, 2'b01);
    seen = 0;
    repeat (40) begin
      tick;
      if (out_valid) seen++;
    end
    chk("flush.quiet", seen, 0);
    run_op("flush.add", 5'b00000, 32'd2, 32'd3, 32'd5, 1, 0);

    // reset ten cycles into a divide
    alu_op = 5'b10100; A = 32'd100; B = 32'd3; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    chk("rst.calc", {out_valid, in_ready, out_zero, alu_out}, {1'b0, 1'b0, 1'b1, 32'h0});
    rst = 1'b0;
    tick;
    chk("rst.ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      tick;
      if (out_valid) seen++;
    end
    chk("rst.quiet", seen, 0);
    run_op("rst.add", 5'b00000, 32'd2, 32'd3, 32'd5, 1, 0);
`else
    run_op("mul.off", 5'b10000, 32'h3, 32'h4, 32'h0, MLAT, 0);
    run_op("div.off", 5'b10100, 32'h9, 32'h3, 32'h0, MLAT, 0);
`endif

    // no acceptance while a result waits; in_valid in DONE is ignored
    alu_op = 5'b00000; A = 32'd1; B = 32'd2; in_valid = 1'b1;
    tick;
    alu_op = 5'b00001; A = 32'd9; B = 32'd1;
    tick;
    tick;
    chk("done.block", {out_valid, in_ready, alu_out}, {1'b1, 1'b0, 32'd3});
    in_valid = 1'b0;

    // flush in DONE drops the result even with out_ready high
    flush = 1'b1; out_ready = 1'b1;
    tick;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush.done", {out_valid, in_ready}, 2'b01);

    // flush overrides in_valid in IDLE
    alu_op = 5'b00000; A = 32'd4; B = 32'd4; in_valid = 1'b1; flush = 1'b1;
    tick;
    in_valid = 1'b0; flush = 1'b0;
    tick;
    chk("flush.idle", {out_valid, in_ready}, 2'b01);
    run_op("final", 5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
